// File: rtl/mmio_interval_timer.sv
// Memory-mapped down-counting interval timer with sticky timeout flag and level interrupt.
// Register window: STATUS, CONTROL, PERIOD and SNAP at offsets 0x0, 0x4, 0x8 and 0xC.
module mmio_interval_timer #(
  parameter logic [31:0] BASE_ADDR    = 32'hFF202000,
  parameter logic [31:0] RESET_PERIOD = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        irq
);

  logic        to_q, to_d;
  logic        run_q, run_d;
  logic        ito_q, ito_d;
  logic        cont_q, cont_d;
  logic [31:0] period_q, period_d;
  logic [31:0] count_q, count_d;
  logic [31:0] snap_q, snap_d;

  logic [1:0]  offset;
  logic        wr_status, wr_ctrl, wr_period, wr_snap;
  logic        start, stop, tick;
  logic [31:0] eff_period;

  // Address decode and write strobes.
  always_comb begin
    offset    = addr[3:2];
    sel       = (addr[31:4] == BASE_ADDR[31:4]) && (addr[1:0] == 2'b00);
    wr_status = we && sel && (offset == 2'd0);
    wr_ctrl   = we && sel && (offset == 2'd1);
    wr_period = we && sel && (offset == 2'd2);
    wr_snap   = we && sel && (offset == 2'd3);
    // STOP beats START when both bits are set.
    start      = wr_ctrl && wdata[2] && !wdata[3];
    stop       = wr_ctrl && wdata[3];
    eff_period = (period_q == 32'd0) ? 32'd1 : period_q;
    tick       = run_q && (count_q == 32'd0);
  end

  // Next-state logic for counter and registers.
  always_comb begin
    to_d     = to_q;
    run_d    = run_q;
    ito_d    = ito_q;
    cont_d   = cont_q;
    period_d = period_q;
    count_d  = count_q;
    snap_d   = snap_q;

    // Timeout set wins over a same-cycle software clear.
    if (tick) begin
      to_d = 1'b1;
    end else if (wr_status) begin
      to_d = 1'b0;
    end

    if (wr_ctrl) begin
      ito_d  = wdata[0];
      cont_d = wdata[1];
    end

    // New PERIOD only matters at the next reload or START.
    if (wr_period) begin
      period_d = wdata;
    end

    // Snapshot sees the pre-edge count.
    if (wr_snap) begin
      snap_d = count_q;
    end

    if (stop) begin
      run_d = 1'b0;
    end else if (start) begin
      run_d   = 1'b1;
      count_d = eff_period - 32'd1;
    end else if (tick) begin
      // CONT is sampled at the timeout, so mid-run changes apply here.
      run_d   = cont_q;
      count_d = eff_period - 32'd1;
    end else if (run_q) begin
      count_d = count_q - 32'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_q     <= 1'b0;
      run_q    <= 1'b0;
      ito_q    <= 1'b0;
      cont_q   <= 1'b0;
      period_q <= RESET_PERIOD;
      count_q  <= 32'd0;
      snap_q   <= 32'd0;
    end else begin
      to_q     <= to_d;
      run_q    <= run_d;
      ito_q    <= ito_d;
      cont_q   <= cont_d;
      period_q <= period_d;
      count_q  <= count_d;
      snap_q   <= snap_d;
    end
  end

  // Side-effect-free combinational read mux and interrupt.
  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      unique case (offset)
        2'd0: rdata = {30'd0, run_q, to_q};
        2'd1: rdata = {30'd0, cont_q, ito_q};
        2'd2: rdata = period_q;
        2'd3: rdata = snap_q;
        default: rdata = 32'd0;
      endcase
    end
    irq = to_q && ito_q;
  end

endmodule
